// File: rtl/interrupt_controller_if.sv
// Signal bundle between the interrupt front end and the core's pipeline control.
// The controller takes the slave side; the core side (or a bench) takes the master side.
interface interrupt_controller_if #(
  parameter int unsigned PC_W = 10
) ();

  logic            int_in;
  logic            sei;
  logic            cli;
  logic            retie;
  logic            retid;
  logic            flag_c;
  logic            flag_z;
  logic            pipe_safe;

  logic            int_req;
  logic            int_flag;
  logic [PC_W-1:0] int_vector;
  logic            shadow_c;
  logic            shadow_z;
  logic            flag_restore;
  logic            int_active;
  logic            pending;

  modport master (
    output int_in, sei, cli, retie, retid, flag_c, flag_z, pipe_safe,
    input  int_req, int_flag, int_vector, shadow_c, shadow_z, flag_restore, int_active, pending
  );

  modport slave (
    input  int_in, sei, cli, retie, retid, flag_c, flag_z, pipe_safe,
    output int_req, int_flag, int_vector, shadow_c, shadow_z, flag_restore, int_active, pending
  );

endinterface

// File: rtl/interrupt_controller.sv
// Interrupt front end: synchronizes and edge-detects the external line, owns the I flag and
// C/Z shadows, and releases a single take into the pipeline at a hazard-free safe point.
module interrupt_controller #(
  parameter int unsigned     SYNC_STAGES = 2,
  parameter int unsigned     PC_W        = 10,
  parameter logic [PC_W-1:0] VECTOR      = 10'h3FF
) (
  input logic                   clk,
  input logic                   reset_n,
  interrupt_controller_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StEnter0,
    StEnter1,
    StEnter2,
    StIsr
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;
  logic                   pending_q, pending_d;
  logic                   flag_q, flag_d;
  logic                   shadow_c_q, shadow_c_d;
  logic                   shadow_z_q, shadow_z_d;
  logic                   restore_q, restore_d;

  logic                   sync_out;
  logic                   edge_det;
  logic                   take;
  logic                   ret;

  always_comb begin
    sync_out = sync_q[SYNC_STAGES-1];
    edge_det = sync_out & ~dly_q;
    sync_d   = {sync_q[SYNC_STAGES-2:0], bus.int_in};
    dly_d    = sync_out;
  end

  // A take needs the I flag as registered; a CLI retiring this cycle only drops ARMED next cycle.
  always_comb begin
    take = reset_n && (state_q == StArmed) && flag_q && bus.pipe_safe;
    ret  = (state_q == StIsr) && (bus.retie || bus.retid);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (pending_q && flag_q) state_d = StArmed;
      end
      StArmed: begin
        if (!flag_q) begin
          state_d = StIdle;
        end else if (take) begin
          state_d = StEnter0;
        end
      end
      StEnter0: state_d = StEnter1;
      StEnter1: state_d = StEnter2;
      StEnter2: state_d = StIsr;
      StIsr: begin
        if (ret) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pending_d  = edge_det | (pending_q & ~take);
    shadow_c_d = shadow_c_q;
    shadow_z_d = shadow_z_q;
    if (take) begin
      shadow_c_d = bus.flag_c;
      shadow_z_d = bus.flag_z;
    end
    restore_d = ret;
    // Clears dominate sets, so CLI beats SEI and the take always masks further requests.
    flag_d = flag_q;
    if (bus.sei || bus.retie) flag_d = 1'b1;
    if (bus.cli || bus.retid || take) flag_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      sync_q     <= '0;
      dly_q      <= 1'b0;
      pending_q  <= 1'b0;
      flag_q     <= 1'b0;
      shadow_c_q <= 1'b0;
      shadow_z_q <= 1'b0;
      restore_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      dly_q      <= dly_d;
      pending_q  <= pending_d;
      flag_q     <= flag_d;
      shadow_c_q <= shadow_c_d;
      shadow_z_q <= shadow_z_d;
      restore_q  <= restore_d;
    end
  end

  assign bus.int_req      = take;
  assign bus.int_flag     = flag_q;
  assign bus.int_vector   = VECTOR;
  assign bus.shadow_c     = shadow_c_q;
  assign bus.shadow_z     = shadow_z_q;
  assign bus.flag_restore = restore_q;
  assign bus.int_active   = (state_q == StEnter0) || (state_q == StEnter1) ||
                            (state_q == StEnter2) || (state_q == StIsr);
  assign bus.pending      = pending_q;

  a_req_single: assert property (@(posedge clk) disable iff (!reset_n)
    bus.int_req |=> !bus.int_req);

  a_req_masked: assert property (@(posedge clk) disable iff (!reset_n)
    bus.int_req |-> (bus.int_flag && !bus.int_active));

  a_restore_single: assert property (@(posedge clk) disable iff (!reset_n)
    bus.flag_restore |=> !bus.flag_restore);

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scenarios followed by random traffic, every cycle compared against a
// cycle-level behavioural model of the interrupt front end.
module tb_interrupt_controller;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned PcW        = 10;
  localparam logic [9:0]  Vector     = 10'h3FF;

  logic clk = 1'b0;
  logic reset_n;

  interrupt_controller_if #(.PC_W(PcW)) bus ();

  interrupt_controller #(
    .SYNC_STAGES(SyncStages),
    .PC_W       (PcW),
    .VECTOR     (Vector)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: history of sampled int_in, phase flags and a countdown for the entry sequence.
  bit [SyncStages:0] m_hist;
  bit m_pending, m_flag, m_shc, m_shz, m_restore, m_armed, m_isr, m_valid;
  int m_enter;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_req();
    return (reset_n === 1'b1) && m_armed && m_flag && (bus.pipe_safe === 1'b1);
  endfunction

  task automatic compare_model();
    if (!m_valid) return;
    check("int_req", bus.int_req, m_req());
    check("int_flag", bus.int_flag, m_flag);
    check("int_vector", bus.int_vector, Vector);
    check("shadow_c", bus.shadow_c, m_shc);
    check("shadow_z", bus.shadow_z, m_shz);
    check("flag_restore", bus.flag_restore, m_restore);
    check("int_active", bus.int_active, (m_enter > 0) || m_isr);
    check("pending", bus.pending, m_pending);
  endtask

  task automatic model_step();
    bit edge_b, take, ret;
    if (reset_n !== 1'b1) begin
      m_hist = '0; m_pending = 0; m_flag = 0; m_shc = 0; m_shz = 0;
      m_restore = 0; m_armed = 0; m_isr = 0; m_enter = 0;
      return;
    end
    edge_b = m_hist[SyncStages-1] && !m_hist[SyncStages];
    take   = m_req();
    ret    = m_isr && (bus.retie || bus.retid);
    if (m_isr) begin
      if (ret) m_isr = 0;
    end else if (m_enter > 0) begin
      m_enter--;
      if (m_enter == 0) m_isr = 1;
    end else if (m_armed) begin
      if (!m_flag) m_armed = 0;
      else if (take) begin
        m_armed = 0;
        m_enter = 3;
      end
    end else if (m_pending && m_flag) begin
      m_armed = 1;
    end
    m_restore = ret;
    if (take) begin
      m_shc = bus.flag_c;
      m_shz = bus.flag_z;
    end
    m_pending = edge_b || (m_pending && !take);
    if (bus.sei || bus.retie) m_flag = 1;
    if (bus.cli || bus.retid || take) m_flag = 0;
    m_hist = {m_hist[SyncStages-1:0], bus.int_in};
  endtask

  task automatic tick();
    @(negedge clk);
    compare_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_sei();
    bus.sei = 1'b1;
    tick();
    bus.sei = 1'b0;
  endtask

  initial begin
    m_valid = 0;
    reset_n = 1'b0;
    bus.int_in = 0; bus.sei = 0; bus.cli = 0; bus.retie = 0; bus.retid = 0;
    bus.flag_c = 0; bus.flag_z = 0; bus.pipe_safe = 0;
    @(posedge clk);
    model_step();
    #1;
    m_valid = 1;
    tick();
    check("rst_pending", bus.pending, 1'b0);
    check("rst_int_flag", bus.int_flag, 1'b0);
    check("rst_vector", bus.int_vector, Vector);
    reset_n = 1'b1;

    // Basic take
    pulse_sei();
    bus.int_in = 1; bus.pipe_safe = 1; bus.flag_c = 1; bus.flag_z = 0;
    ticks(3);
    check("basic_pending_e3", bus.pending, 1'b1);
    check("basic_noreq_c4", bus.int_req, 1'b0);
    tick();
    check("basic_req_c5", bus.int_req, 1'b1);
    tick();
    check("basic_req_c6", bus.int_req, 1'b0);
    check("basic_active_c6", bus.int_active, 1'b1);
    check("basic_shadow_c", bus.shadow_c, 1'b1);
    check("basic_shadow_z", bus.shadow_z, 1'b0);
    check("basic_int_flag", bus.int_flag, 1'b0);
    bus.flag_c = 0; bus.flag_z = 1;
    ticks(3);
    check("basic_isr_active", bus.int_active, 1'b1);

    // Return with RETIE
    bus.retie = 1;
    tick();
    bus.retie = 0;
    check("retie_restore", bus.flag_restore, 1'b1);
    check("retie_flag", bus.int_flag, 1'b1);
    check("retie_idle", bus.int_active, 1'b0);
    check("retie_shadow_held", bus.shadow_c, 1'b1);
    tick();
    check("retie_restore_1cyc", bus.flag_restore, 1'b0);

    // Safe-point stall
    bus.int_in = 0;
    ticks(3);
    bus.pipe_safe = 0; bus.int_in = 1;
    ticks(4);
    for (int i = 0; i < 7; i++) begin
      check("stall_noreq", bus.int_req, 1'b0);
      check("stall_pending", bus.pending, 1'b1);
      tick();
    end
    bus.pipe_safe = 1;
    #1;
    check("stall_req", bus.int_req, 1'b1);
    tick();
    check("stall_shadow_z", bus.shadow_z, 1'b1);
    ticks(3);
    bus.retid = 1;
    tick();
    bus.retid = 0;
    check("retid_restore", bus.flag_restore, 1'b1);
    check("retid_flag", bus.int_flag, 1'b0);

    // Masked
    bus.int_in = 0;
    ticks(3);
    bus.int_in = 1;
    ticks(3);
    check("masked_pending", bus.pending, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("masked_noreq", bus.int_req, 1'b0);
      tick();
    end
    pulse_sei();
    tick();
    check("masked_take_after_sei", bus.int_req, 1'b1);
    tick();
    bus.int_in = 0;
    ticks(3);

    // Edge during ISR, then CLI while armed
    bus.int_in = 1;
    ticks(3);
    for (int i = 0; i < 3; i++) begin
      check("isr_edge_pending", bus.pending, 1'b1);
      check("isr_edge_active", bus.int_active, 1'b1);
      check("isr_no_nest", bus.int_req, 1'b0);
      tick();
    end
    bus.retie = 1;
    tick();
    bus.retie = 0;
    tick();
    check("retake_after_ret", bus.int_req, 1'b1);
    bus.pipe_safe = 0; bus.cli = 1;
    tick();
    bus.cli = 0; bus.pipe_safe = 1;
    tick();
    check("cli_armed_idle", bus.int_active, 1'b0);
    check("cli_armed_pending", bus.pending, 1'b1);
    check("cli_armed_noreq", bus.int_req, 1'b0);

    // Reset in ENTER1
    pulse_sei();
    tick();
    check("rst_seq_req", bus.int_req, 1'b1);
    ticks(2);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rst_mid_pending", bus.pending, 1'b0);
    check("rst_mid_active", bus.int_active, 1'b0);
    check("rst_mid_shadow_z", bus.shadow_z, 1'b0);
    check("rst_mid_flag", bus.int_flag, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check("rst_mid_noreq", bus.int_req, 1'b0);
      tick();
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      if ($urandom_range(0, 5) == 0) bus.int_in = ~bus.int_in;
      bus.sei       = ($urandom_range(0, 7) == 0);
      bus.cli       = ($urandom_range(0, 15) == 0);
      r             = $urandom_range(0, 15);
      bus.retie     = (r == 0);
      bus.retid     = (r == 1);
      bus.flag_c    = $urandom_range(0, 1) != 0;
      bus.flag_z    = $urandom_range(0, 1) != 0;
      bus.pipe_safe = $urandom_range(0, 9) < 7;
      reset_n       = ($urandom_range(0, 299) != 0);
      tick();
    end
    reset_n = 1'b1;
    bus.sei = 0; bus.cli = 0; bus.retie = 0; bus.retid = 0;
    ticks(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Interrupt front end for the pipelined RAT core, sitting between the external interrupt pin and `pipeline_control`.
- Synchronizes and edge-detects the external line and holds a pending request.
- Owns the interrupt-enable (I) flag and saves/restores the C/Z shadow flags.
- Releases an interrupt into the pipeline only when the hazard controller reports a safe point, then tracks the 3-cycle entry sequence and the ISR until RETIE/RETID.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on `int_in` (≥2).
- `PC_W`, 10: program-counter width.
- `VECTOR`, 10'h3FF: ISR entry address driven on `int_vector`.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `int_in` in 1: asynchronous external interrupt line; rising edge requests service.
- `sei`, `cli` in 1 each: SEI/CLI retiring in execute (1-cycle pulses).
- `retie`, `retid` in 1 each: RETIE/RETID retiring (1-cycle pulses).
- `flag_c`, `flag_z` in 1 each: live C/Z flags.
- `pipe_safe` in 1: hazard controller is in CHECK with no branch-miss, call, return or RAW stall in flight.
- `int_req` out 1: 1-cycle interrupt take; drives `pipeline_control.interrupt`.
- `int_flag` out 1: I flag; drives `pipeline_control.interrupt_flag`.
- `int_vector` out PC_W: constant `VECTOR`.
- `shadow_c`, `shadow_z` out 1 each: saved flags.
- `flag_restore` out 1: 1-cycle pulse that tells the flag register to load the shadow values.
- `int_active` out 1: entry sequence or ISR in progress.
- `pending` out 1: edge latched, not yet taken.

## Operation
Input conditioning:
- `int_in` passes through `SYNC_STAGES` flops, then a delay flop.
- `edge` = synchronized output high while the delayed copy is low.
- `edge` sets `pending`. `pending` is cleared only on the take cycle, unless `edge` occurs in that same cycle, in which case it stays set.

I flag:
- `sei` sets it. `cli` clears it. `cli` wins if both are asserted.
- Cleared on take.
- RETIE sets it. RETID clears it.

FSM states: IDLE, ARMED, ENTER0, ENTER1, ENTER2, ISR.
- IDLE → ARMED when `pending && int_flag`.
- ARMED:
  - If `!int_flag` (CLI arrived): → IDLE, `pending` kept.
  - Else `int_req = pipe_safe` (combinational).
  - When `int_req` = 1: capture `flag_c`/`flag_z` into the shadows, clear `int_flag`, clear `pending`, → ENTER0.
- ENTER0 → ENTER1 → ENTER2 → ISR unconditionally. These align with the pipeline's INT0..INT2.
- ISR:
  - On `retie` or `retid`: pulse `flag_restore` for 1 cycle, set `int_flag` = `retie`, → IDLE.
  - No nesting: `sei` inside an ISR sets `int_flag`, but no take occurs before a return.
- Outside ISR, `retie`/`retid` only set/clear `int_flag`. No `flag_restore` is issued.
- `int_active` = 1 in ENTER0..ENTER2 and ISR.

## Timing
Reset (`reset_n` low at an edge):
- State = IDLE. Synchronizer and delay flops = 0.
- `pending`, `int_flag`, `shadow_c`, `shadow_z`, `flag_restore`, `int_active` = 0.
- `int_req` = 0 throughout. `int_vector` = `VECTOR`.
- Reset asserted mid-sequence (ENTER*/ISR) aborts immediately to these values.

Latency, with `int_in` rising before edge 1 and `SYNC_STAGES` = 2:
- `pending` = 1 after edge 3.
- ARMED after edge 4.
- `int_req` high during cycle 5 if `pipe_safe` = 1 and `int_flag` = 1.
- ENTER0 after edge 5; ISR after edge 8.

Handshake and hold rules:
- `int_req` is never high for two consecutive cycles.
- While ARMED and `pipe_safe` = 0, the request holds indefinitely.
- Shadow values are captured at the take edge and held until the next take.
- A `retie` in the same cycle as ENTER* is ignored, i.e. a return is accepted only in ISR.

## Test plan
- Basic take:
  - Stimulus: `sei`, then `int_in` 0→1 at cycle 0, `pipe_safe` = 1, `flag_c` = 1, `flag_z` = 0.
  - Required: `int_req` pulses exactly in cycle 5; `shadow_c` = 1, `shadow_z` = 0; `int_flag` = 0; `int_active` high from cycle 6.
- Safe-point stall:
  - Stimulus: as above, but `pipe_safe` held 0 for 7 cycles.
  - Required: `int_req` stays low, `pending` = 1; `int_req` pulses the first cycle `pipe_safe` = 1.
- Masked:
  - Stimulus: `int_flag` = 0 (no `sei`), then an edge on `int_in`.
  - Required: `pending` = 1, no `int_req`; after `sei`, take follows 2 cycles later.
- Return:
  - Stimulus: `retie` in ISR.
  - Required: `flag_restore` for 1 cycle, `int_flag` = 1, state IDLE.
  - Repeat with `retid` → `int_flag` = 0.
- Edge during ISR:
  - Stimulus: second `int_in` edge while in ISR, then `retie`.
  - Required: `pending` stays 1 through ISR; new take 2 cycles after return.
  - Stimulus: `cli` while ARMED. Required: back to IDLE with `pending` = 1.
- Reset mid-ISR:
  - Stimulus: `reset_n` = 0 for 1 cycle in ENTER1.
  - Required: all outputs at reset values next cycle, `pending` = 0; `int_req` never asserts.
